// File: rtl/ififo_pkg.sv
// Shared definitions for the fetch -> dispatch instruction FIFO.
// Fetch and dispatch both import ififo_entry_t from here so the packet
// layout is defined exactly once.
package ififo_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int IFIFO_DEPTH = 8;

    // One predicted fetch packet (98 bits, instr in the MSBs).
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
        logic                   is_cond_br;
        logic                   br_dir_pred;
        logic [ADDR_WIDTH-1:0]  br_target_pred;
    } ififo_entry_t;

    localparam int ENTRY_WIDTH = $bits(ififo_entry_t);

endpackage

// File: rtl/ififo_fifo_ptr_ctrl.sv
// Pointer bookkeeping for the instruction FIFO: read/write pointers with a
// wrap bit, full/empty/occupancy, and the flush/reset pointer clear.
module fifo_ptr_ctrl #(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push_valid,
    input  logic                 pop_ready,
    output logic                 enq,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH-1:0] wr_addr,
    output logic [PTR_WIDTH-1:0] rd_addr,
    output logic [PTR_WIDTH:0]   count
);

    localparam logic [PTR_WIDTH:0] PTR_ONE   = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);

    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic               deq;

    // Full/empty come only from the registered pointers, so neither handshake
    // output depends combinationally on the other side's input.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                  (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);
        enq     = push_valid & ~full;
        deq     = pop_ready & ~empty;
        count   = wr_ptr - rd_ptr;
        wr_addr = wr_ptr[PTR_WIDTH-1:0];
        rd_addr = rd_ptr[PTR_WIDTH-1:0];
    end

    // Pointer update; reset and flush both return to the origin and drop any
    // same-cycle enqueue/dequeue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Structural invariants of the handshake and the occupancy range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq && full))   else $error("ififo: enqueue while full");
            assert (!(deq && empty))  else $error("ififo: dequeue while empty");
            assert (count <= DEPTH_CNT) else $error("ififo: occupancy out of range");
        end
    end

endmodule

// File: rtl/ififo.sv
// Instruction FIFO between fetch and dispatch. Holds the entry storage and
// the head read mux; pointer control lives in fifo_ptr_ctrl.
module ififo
    import ififo_pkg::*;
#(
    parameter int DEPTH = IFIFO_DEPTH,
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_ififo_valid,
    output logic                   fetch_ififo_ready,
    input  logic [ENTRY_WIDTH-1:0] fetch_ififo_data,
    output logic                   ififo_dispatch_valid,
    input  logic                   ififo_dispatch_ready,
    output logic [ENTRY_WIDTH-1:0] ififo_dispatch_data,
    input  logic                   flush,
    output logic [PTR_WIDTH:0]     ififo_count
);

    logic                   enq;
    logic                   full;
    logic                   empty;
    logic [PTR_WIDTH-1:0]   wr_addr;
    logic [PTR_WIDTH-1:0]   rd_addr;
    logic [ENTRY_WIDTH-1:0] storage [DEPTH];

    fifo_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_ptr_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (fetch_ififo_valid),
        .pop_ready  (ififo_dispatch_ready),
        .enq        (enq),
        .full       (full),
        .empty      (empty),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .count      (ififo_count)
    );

    // Entry storage: cleared on reset, written on an accepted enqueue; a
    // flush suppresses the write but leaves existing contents in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (enq && !flush) begin
            storage[wr_addr] <= fetch_ififo_data;
        end
    end

    // Handshake outputs and the combinational head read (no empty bypass).
    always_comb begin
        fetch_ififo_ready    = ~full;
        ififo_dispatch_valid = ~empty;
        ififo_dispatch_data  = storage[rd_addr];
    end

endmodule
